regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port arbiter and post-reset clear sequencer for the 3-port register file. It shares the single write port (we3/wa3/wd3) between two writeback requesters, A (ALU result) and B (load result), using valid/ready handshakes and round-robin arbitration. Optionally, after reset it zeroes every architectural register before it accepts any traffic. It sits between the writeback stage and the register file; read ports are not touched.

## Interface
- n, 16, data width in bits (matches register width)
- r, 3, register address width; the file has 2**r registers
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active low
- a_valid  input  1  requester A has a write pending
- a_addr  input  r  destination register for A
- a_data  input  n  write data for A
- a_ready  output  1  A's write is accepted this cycle
- b_valid, b_addr, b_data  input  1/r/n  same meanings for requester B
- b_ready  output  1  B's write is accepted this cycle
- we3  output  1  register-file write enable (registered)
- wa3  output  r  register-file write address (registered)
- wd3  output  n  register-file write data (registered)
- clr_busy  output  1  clear sequence in progress

## Operation
- States: CLEAR, RUN. On reset the block enters CLEAR if clearing is compiled in, otherwise RUN.
- CLEAR:
  - A counter idx resets to 1.
  - Each rising edge drives we3=1, wa3=idx, wd3=0, then increments idx.
  - On the edge that issues idx = 2**r-1, the state moves to RUN.
  - a_ready and b_ready are 0 throughout. Register 0 is never written.
- RUN, grant (combinational):
  - If only one requester is valid, that requester gets ready=1.
  - If both are valid, the requester not granted last gets ready=1. A one-bit pointer last_b records this and resets to 1, so A wins the first tie.
  - Ready never asserts without the matching valid. At most one ready is high per cycle.
- Transfer: occurs when valid && ready at a rising edge. That edge sets last_b to the granted side and registers we3=1, wa3=addr, wd3=data.
- With no transfer at an edge, we3 registers 0. wa3/wd3 hold their previous values.
- Write to register 0: the handshake completes normally (ready=1) but we3 registers 0. The transfer still updates last_b.
- Requesters hold addr/data stable while valid && !ready. The arbiter does not buffer.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - we3=0, wa3=0, wd3=0, a_ready=0, b_ready=0, last_b=1, idx=1.
  - clr_busy=1 with REGFILE_CLEAR_EN defined, 0 without it.
- Latency: a transfer at edge t appears on we3/wa3/wd3 after edge t. The register file commits at edge t+1.
- Throughput: one write per cycle. Under continuous contention, A and B alternate grants.
- CLEAR length: exactly 2**r-1 cycles (7 for r=3).
  - clr_busy falls after the edge issuing the last clear write.
  - The first ready can assert in the next cycle.
- Reset mid-clear or mid-transfer: everything returns immediately to reset values, and the sequence restarts from idx=1. A write registered before reset is lost if it has not yet been committed.
- Simultaneous valid on both sides with the same wa3: only the granted write issues. The other issues in the following cycle, so the last write wins in grant order.

## Configuration
- REGFILE_CLEAR_EN defined:
  - The CLEAR state and idx counter are compiled in.
  - Reset leads to 2**r-1 zeroing writes before RUN.
- REGFILE_CLEAR_EN undefined:
  - There is no CLEAR state, and the block resets directly into RUN.
  - clr_busy is tied to 0.
  - The first ready can assert in the first cycle after reset.

## Test plan
- Clear sequence (macro on, r=3): release rst_n → edges 1..7 show we3=1, wa3=1..7, wd3=0. Both readies stay 0 throughout, and clr_busy=0 after edge 7.
- Single requester: A valid with addr=3 and data=16'hBEEF, B idle → a_ready=1. The next cycle shows we3=1, wa3=3, wd3=16'hBEEF. The cycle after that shows we3=0.
- Contention: A and B held valid for 4 cycles → grant order A, B, A, B, with exactly one ready high each cycle.
- Register 0: B valid with addr=0 and data=16'h1234 → b_ready=1, and the next cycle shows we3=0. The following tie then grants A.
- Reset mid-clear: pull rst_n low after edge 3 of CLEAR → we3=0 and clr_busy=1 immediately. On release, the sequence restarts at wa3=1.
- Macro off: release rst_n with A valid → a_ready=1 in the first cycle, and clr_busy stays 0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the 3-port register file (requesters A/B).
// Define REGFILE_CLEAR_EN to zero registers 1..2**R-1 after reset before accepting traffic.
module regfile_wr_arbiter #(
  parameter int N = 16,
  parameter int R = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  input  logic [R-1:0] a_addr,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [R-1:0] b_addr,
  input  logic [N-1:0] b_data,
  output logic         b_ready,
  output logic         we3,
  output logic [R-1:0] wa3,
  output logic [N-1:0] wd3,
  output logic         clr_busy
);

  logic         run;
  logic         clr_wr;
  logic [R-1:0] clr_idx;
  logic         last_b;
  logic         gnt_a, gnt_b;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [R-1:0] IDX_LAST = {R{1'b1}};

  state_t       state_q, state_d;
  logic [R-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= R'(1);
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) idx_q <= idx_q + R'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (idx_q == IDX_LAST) state_d = RUN;
      default: state_d = state_q;
    endcase
  end

  // RUN is only reachable after reset is released, so no extra gating is needed
  assign run      = (state_q == RUN);
  assign clr_wr   = (state_q == CLEAR);
  assign clr_idx  = idx_q;
  assign clr_busy = (state_q == CLEAR);
`else
  // Without clearing the block sits in RUN, but readies stay low while reset is held
  assign run      = rst_n;
  assign clr_wr   = 1'b0;
  assign clr_idx  = '0;
  assign clr_busy = 1'b0;
`endif

  // Tie goes to whoever was not granted last
  assign gnt_a   = run && a_valid && (!b_valid ||  last_b);
  assign gnt_b   = run && b_valid && (!a_valid || !last_b);
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3    <= 1'b0;
      wa3    <= '0;
      wd3    <= '0;
      last_b <= 1'b1;
    end else begin
      we3 <= 1'b0;
      if (clr_wr) begin
        we3 <= 1'b1;
        wa3 <= clr_idx;
        wd3 <= '0;
      end else if (gnt_a) begin
        last_b <= 1'b0;
        if (a_addr != '0) begin
          we3 <= 1'b1;
          wa3 <= a_addr;
          wd3 <= a_data;
        end
      end else if (gnt_b) begin
        last_b <= 1'b1;
        if (b_addr != '0) begin
          we3 <= 1'b1;
          wa3 <= b_addr;
          wd3 <= b_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter (N=16, R=3); follows REGFILE_CLEAR_EN like the RTL.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        we3;
  logic [2:0]  wa3;
  logic [15:0] wd3;
  logic        clr_busy;

  typedef struct packed {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  regfile_wr_arbiter #(.N(16), .R(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("we3", we3, e.we);
      if (e.we) begin
        chk("wa3", wa3, e.wa);
        chk("wd3", wd3, e.wd);
      end
    end
  endtask

  // Starts and ends at a negedge; ea/eb are the hand-derived readies for this cycle
  task automatic step(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                      input logic bv, input logic [2:0] ba, input logic [15:0] bd,
                      input logic ea, input logic eb);
    exp_t e;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("clr_busy_run", clr_busy, 0);
    e = '0;
    if (ea && aa != 3'd0)      e = '{1'b1, aa, ad};
    else if (eb && ba != 3'd0) e = '{1'b1, ba, bd};
    sb.push_back(e);
    @(posedge clk); #1;
    pop_chk();
    @(negedge clk);
  endtask

  task automatic clr_step(input logic [2:0] idx);
    a_valid = 1'b1; a_addr = 3'd6; a_data = 16'hAAAA;
    b_valid = 1'b1; b_addr = 3'd7; b_data = 16'hBBBB;
    #1;
    chk("clr_a_ready", a_ready, 0);
    chk("clr_b_ready", b_ready, 0);
    chk("clr_busy", clr_busy, 1);
    sb.push_back('{1'b1, idx, 16'h0000});
    @(posedge clk); #1;
    pop_chk();
    @(negedge clk);
  endtask

  task automatic reset_chk();
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
`ifdef REGFILE_CLEAR_EN
    chk("rst_clr_busy", clr_busy, 1);
`else
    chk("rst_clr_busy", clr_busy, 0);
`endif
  endtask

  task automatic clear_seq();
`ifdef REGFILE_CLEAR_EN
    for (int i = 1; i <= 7; i++) clr_step(3'(i));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 3'd3; a_data = 16'hBEEF;
    b_valid = 1'b0; b_addr = 3'd0; b_data = 16'h0000;
    repeat (2) @(negedge clk);
    reset_chk();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef REGFILE_CLEAR_EN
    // Interrupt the clear after edge 3, then let it run to completion
    for (int i = 1; i <= 3; i++) clr_step(3'(i));
    rst_n = 1'b0;
    reset_chk();
    @(negedge clk);
    rst_n = 1'b1;
    clear_seq();
`endif

    // Single requester; first ready right after reset (or clear)
    step(1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0000, 1, 0);
    step(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0);

    // Register 0: handshake completes, no write
    step(0, 3'd0, 16'h0000, 1, 3'd0, 16'h1234, 0, 1);

    // Contention: A wins the first tie, then alternate
    step(1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 1, 0);
    step(1, 3'd1, 16'h0111, 1, 3'd2, 16'h0202, 0, 1);
    step(1, 3'd1, 16'h0111, 1, 3'd2, 16'h0222, 1, 0);
    step(1, 3'd4, 16'h0444, 1, 3'd2, 16'h0222, 0, 1);

    // Same destination: granted write first, loser next cycle
    step(1, 3'd5, 16'h1111, 1, 3'd5, 16'h2222, 1, 0);
    step(0, 3'd0, 16'h0000, 1, 3'd5, 16'h2222, 0, 1);

    // Loser holds while the other side streams
    step(1, 3'd6, 16'h6666, 0, 3'd0, 16'h0000, 1, 0);
    step(1, 3'd7, 16'h7777, 1, 3'd1, 16'hCAFE, 0, 1);
    step(1, 3'd7, 16'h7777, 0, 3'd0, 16'h0000, 1, 0);

    // Reset right after a transfer is registered
    step(1, 3'd2, 16'h5555, 0, 3'd0, 16'h0000, 1, 0);
    rst_n = 1'b0;
    sb.delete();
    reset_chk();
    @(negedge clk);
    rst_n = 1'b1;
    clear_seq();
    step(1, 3'd2, 16'h5A5A, 1, 3'd3, 16'hA5A5, 1, 0);
    step(0, 3'd0, 16'h0000, 1, 3'd3, 16'hA5A5, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
